// File: rtl/miriscv_arb_pkg.sv
// Shared types and default widths for the miriscv data-port arbiter.
// Holds the arbiter state encoding, the request bundle layout and a
// helper that maps a master index onto its ownership state.
package miriscv_arb_pkg;

  localparam int ARB_ADDR_W    = 32;
  localparam int ARB_DATA_W    = 32;
  localparam int ARB_BE_W      = ARB_DATA_W / 8;
  localparam int ARB_MAX_BURST = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // Request bundle at the default widths (the RAM-side view of one access).
  typedef struct packed {
    logic                  we;
    logic [ARB_BE_W-1:0]   be;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
  } mem_req_t;

  // Ownership state that corresponds to granting the given master.
  function automatic arb_state_t own_state(input logic master);
    return master ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/miriscv_data_arbiter.sv
// Two-master round-robin arbiter in front of the single miriscv_ram data port.
// Latency: grant and RAM strobe combinational; read data returns 1 cycle after a granted read.
// Backpressure: a master holds req until gnt; the owner may keep the port for MAX_BURST grants under contention.
module miriscv_data_arbiter
  import miriscv_arb_pkg::*;
#(
  parameter int ADDR_W    = ARB_ADDR_W,
  parameter int DATA_W    = ARB_DATA_W,
  parameter int MAX_BURST = ARB_MAX_BURST
) (
  input  logic                clk_i,
  input  logic                rst_n_i,

  input  logic                m0_req_i,
  input  logic                m0_we_i,
  input  logic [DATA_W/8-1:0] m0_be_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  output logic                m0_gnt_o,
  output logic                m0_rvalid_o,
  output logic [DATA_W-1:0]   m0_rdata_o,

  input  logic                m1_req_i,
  input  logic                m1_we_i,
  input  logic [DATA_W/8-1:0] m1_be_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  output logic                m1_gnt_o,
  output logic                m1_rvalid_o,
  output logic [DATA_W-1:0]   m1_rdata_o,

  output logic                ram_req_o,
  output logic                ram_we_o,
  output logic [DATA_W/8-1:0] ram_be_o,
  output logic [ADDR_W-1:0]   ram_addr_o,
  output logic [DATA_W-1:0]   ram_wdata_o,
  input  logic [DATA_W-1:0]   ram_rdata_i
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

  typedef struct packed {
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } port_req_t;

  arb_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             last, last_nxt;
  logic [1:0]       req;
  logic [1:0]       gnt;
  logic [1:0]       rvalid;
  logic             own;
  logic             pick;
  port_req_t        sel;

  assign req = {m1_req_i, m0_req_i};
  assign own = (state == OWN1);

  // Grant selection and next arbitration state from registered state and live requests.
  always_comb begin
    gnt       = 2'b00;
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    pick      = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the master that did not win last time goes first.
        pick = (req[0] & req[1]) ? ~last : req[1];
        if (|req) begin
          gnt[pick] = 1'b1;
          state_nxt = own_state(pick);
          cnt_nxt   = '0;
        end
      end
      OWN0, OWN1: begin
        if (req[own] && (!req[~own] || cnt < CNT_MAX)) begin
          // Owner keeps the port. The count saturates so that a long
          // uncontended run still yields as soon as the other master asks.
          gnt[own] = 1'b1;
          if (cnt < CNT_MAX) begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end else if (req[~own]) begin
          // Burst exhausted or owner went quiet: hand over with no bubble.
          gnt[~own] = 1'b1;
          state_nxt = own_state(~own);
          cnt_nxt   = '0;
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    if (gnt[0]) begin
      last_nxt = 1'b0;
    end else if (gnt[1]) begin
      last_nxt = 1'b1;
    end
  end

  // Arbitration state register; reset makes M0 the winner of the first tie.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      last  <= last_nxt;
    end
  end

  // Remember which master owns the read data coming back next cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rvalid <= 2'b00;
    end else begin
      rvalid[0] <= gnt[0] & ~m0_we_i;
      rvalid[1] <= gnt[1] & ~m1_we_i;
    end
  end

  // RAM-side mux: fields of the granted master, all zero when nobody is granted.
  always_comb begin
    sel = '0;
    if (gnt[0]) begin
      sel = '{we: m0_we_i, be: m0_be_i, addr: m0_addr_i, wdata: m0_wdata_i};
    end else if (gnt[1]) begin
      sel = '{we: m1_we_i, be: m1_be_i, addr: m1_addr_i, wdata: m1_wdata_i};
    end
  end

  assign m0_gnt_o    = gnt[0];
  assign m1_gnt_o    = gnt[1];
  assign ram_req_o   = gnt[0] | gnt[1];
  assign ram_we_o    = sel.we;
  assign ram_be_o    = sel.be;
  assign ram_addr_o  = sel.addr;
  assign ram_wdata_o = sel.wdata;

  assign m0_rvalid_o = rvalid[0];
  assign m1_rvalid_o = rvalid[1];
  assign m0_rdata_o  = rvalid[0] ? ram_rdata_i : '0;
  assign m1_rdata_o  = rvalid[1] ? ram_rdata_i : '0;

endmodule
